// File: rtl/mips_wbuf_pkg.sv
// mips_wbuf_pkg: shared types for the MIPS core write buffer.
// Holds the bus FSM state encoding, the queued-store entry layout and the
// byte-merge helper used when stores are coalesced into the youngest entry.
package mips_wbuf_pkg;

  // Bus sequencer states; encoding is fixed so debug views stay stable.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  // One queued store: word address, byte enables and lane-aligned data.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } entry_t;

  localparam logic [3:0]  WE_NONE   = 4'h0;
  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  // Fold a new store into an existing entry: enables are OR-ed and the
  // newly written byte lanes replace the old ones.
  function automatic entry_t merge_bytes(input entry_t      old_e,
                                         input logic [3:0]  new_we,
                                         input logic [31:0] new_data);
    entry_t res;
    res      = old_e;
    res.we   = old_e.we | new_we;
    for (int b = 0; b < 4; b++) begin
      if (new_we[b]) begin
        res.data[8*b +: 8] = new_data[8*b +: 8];
      end else begin
        res.data[8*b +: 8] = old_e.data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_wbuf_fifo.sv
// mips_wbuf_fifo: circular store queue for the write buffer.
// Provides push/pop, an in-place merge into the youngest entry, the head
// entry for the bus, the youngest entry address for merge matching and the
// occupancy count. DEPTH must be a power of two so the pointers wrap for free.
module mips_wbuf_fifo
  import mips_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_i,
  input  entry_t                       push_entry_i,
  input  logic                         pop_i,
  input  logic                         merge_i,
  input  logic [3:0]                   merge_we_i,
  input  logic [31:0]                  merge_data_i,
  output entry_t                       head_o,
  output logic [31:0]                  tail_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   tail_ptr_s;
  logic [CW-1:0]   count_q, count_d;

  assign tail_ptr_s  = wr_ptr_q - PW'(1'b1);
  assign head_o      = mem_q[rd_ptr_q];
  assign tail_addr_o = mem_q[tail_ptr_s].addr;
  assign count_o     = count_q;

  // Storage update: a push writes the slot at the write pointer, a merge
  // rewrites the youngest slot; the top never requests both at once.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && (wr_ptr_q == PW'(i))) begin
        mem_d[i] = push_entry_i;
      end else if (merge_i && (tail_ptr_s == PW'(i))) begin
        mem_d[i] = merge_bytes(mem_q[i], merge_we_i, merge_data_i);
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Pointer and occupancy update; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = push_i ? (wr_ptr_q + PW'(1'b1)) : wr_ptr_q;
    rd_ptr_d = pop_i  ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset discards every queued store.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/mips_wbuf.sv
// mips_wbuf: posted-write buffer between a MIPS core data port and a
// single-outstanding external bus. Stores are queued and drained in order;
// loads wait until the queue is empty and then go straight to the bus.
// Optional build macro: MIPS_WBUF_MERGE_EN -- when defined, a store to the
// address of the youngest queued entry (not currently on the bus) is
// byte-merged into that entry instead of taking a new slot.
module mips_wbuf
  import mips_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DA,
  input  logic [3:0]  we,
  input  logic [31:0] DO,
  input  logic        re,
  output logic [31:0] DI,
  output logic        stall,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int            CW     = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
`ifdef MIPS_WBUF_MERGE_EN
  localparam logic MERGE_EN = 1'b1;
`else
  localparam logic MERGE_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  entry_t        head_s;
  entry_t        push_entry_s;
  logic [31:0]   tail_addr_s;
  logic [CW-1:0] count_s;
  logic          store_s;
  logic          full_s;
  logic          tail_busy_s;
  logic          merge_ok_s;
  logic          read_done_s;
  logic          accept_s;
  logic          push_s;
  logic          merge_s;
  logic          pop_s;

  assign push_entry_s = '{addr: DA, we: we, data: DO};

  mips_wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .merge_i      (merge_s),
    .merge_we_i   (we),
    .merge_data_i (DO),
    .head_o       (head_s),
    .tail_addr_o  (tail_addr_s),
    .count_o      (count_s)
  );

  // Core handshake: decide whether the presented store is taken (push or
  // merge) and whether the core must hold its request this cycle. Fullness
  // uses the registered count, so a store at full waits even if the head
  // retires in the same cycle.
  always_comb begin
    store_s     = (we != WE_NONE);
    full_s      = (count_s == FULL_C);
    tail_busy_s = (state_q == ST_WRITE) && (count_s == ONE_C);
    merge_ok_s  = MERGE_EN && (count_s != ZERO_C) && (tail_addr_s == DA) && !tail_busy_s;
    read_done_s = (state_q == ST_READ) && bus_ack;
    pop_s       = (state_q == ST_WRITE) && bus_ack;
    accept_s    = 1'b0;
    stall       = 1'b0;
    if (!reset) begin
      accept_s = 1'b0;
      stall    = 1'b0;
    end else if (re) begin
      // Load (optionally with a store): the store follows the read.
      accept_s = store_s && read_done_s;
      stall    = !read_done_s;
    end else if (store_s) begin
      accept_s = merge_ok_s || !full_s;
      stall    = !accept_s;
    end else begin
      accept_s = 1'b0;
      stall    = 1'b0;
    end
    merge_s = accept_s && merge_ok_s;
    push_s  = accept_s && !merge_ok_s;
  end

  // Bus sequencer next state: drain stores first, then serve a pending load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((count_s != ZERO_C) || push_s) begin
          state_d = ST_WRITE;
        end else if (re) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus_ack) begin
          if ((count_s != ONE_C) || push_s) begin
            state_d = ST_WRITE;
          end else if (re) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (bus_ack) begin
          state_d = push_s ? ST_WRITE : ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus request and load-return muxing; all bus fields are zero when idle.
  always_comb begin
    bus_req   = 1'b0;
    bus_addr  = WORD_ZERO;
    bus_we    = WE_NONE;
    bus_wdata = WORD_ZERO;
    case (state_q)
      ST_WRITE: begin
        bus_req   = 1'b1;
        bus_addr  = head_s.addr;
        bus_we    = head_s.we;
        bus_wdata = head_s.data;
      end
      ST_READ: begin
        bus_req   = 1'b1;
        bus_addr  = DA;
        bus_we    = WE_NONE;
        bus_wdata = WORD_ZERO;
      end
      default: begin
        bus_req   = 1'b0;
        bus_addr  = WORD_ZERO;
        bus_we    = WE_NONE;
        bus_wdata = WORD_ZERO;
      end
    endcase
    DI = read_done_s ? bus_rdata : WORD_ZERO;
  end

  // Sequencer state register; reset drops any in-flight request at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
